mem_stage: RTL and testbench

//  MEM stage of the 5-stage MIPS pipeline. Directly downstream of the EX-stage ALU.

---
 rtl/mem_stage.sv | 241 ++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: req/ack data-memory port, store lane steering, load extension.
// Optional ack watchdog enabled by defining MEM_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] ex_alu_res,
    input  logic [31:0] ex_wdata,
    input  logic [3:0]  ex_mem_op,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic        flush,
    output logic        mem_stall,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_be,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic        misalign
);

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    state_t      state_q, state_d;
    logic        dm_req_q, dm_req_d;
    logic        dm_we_q, dm_we_d;
    logic [31:0] dm_addr_q, dm_addr_d;
    logic [31:0] dm_wdata_q, dm_wdata_d;
    logic [3:0]  dm_be_q, dm_be_d;
    logic        wb_valid_q, wb_valid_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        wb_reg_write_q, wb_reg_write_d;
    logic        misalign_q, misalign_d;
    logic [3:0]  acc_op_q, acc_op_d;
    logic [1:0]  acc_off_q, acc_off_d;
    logic [4:0]  acc_rd_q, acc_rd_d;
    logic        acc_rw_q, acc_rw_d;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    // Decode of the EX offer: access size 0=byte, 1=half, 2=word.
    logic        is_mem, is_store, misaligned;
    logic [1:0]  sz, off;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;

    always_comb begin
        off      = ex_alu_res[1:0];
        is_mem   = 1'b0;
        is_store = 1'b0;
        sz       = 2'd0;
        case (ex_mem_op)
            OP_LB, OP_LBU: begin is_mem = 1'b1; sz = 2'd0; end
            OP_LH, OP_LHU: begin is_mem = 1'b1; sz = 2'd1; end
            OP_LW:         begin is_mem = 1'b1; sz = 2'd2; end
            OP_SB:         begin is_mem = 1'b1; is_store = 1'b1; sz = 2'd0; end
            OP_SH:         begin is_mem = 1'b1; is_store = 1'b1; sz = 2'd1; end
            OP_SW:         begin is_mem = 1'b1; is_store = 1'b1; sz = 2'd2; end
            default:       ;
        endcase
        misaligned = ((sz == 2'd1) && off[0]) || ((sz == 2'd2) && (off != 2'd0));
        case (sz)
            2'd0: begin
                be_c    = 4'b0001 << off;
                wdata_c = {4{ex_wdata[7:0]}};
            end
            2'd1: begin
                be_c    = off[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{ex_wdata[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = ex_wdata;
            end
        endcase
    end

    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [31:0] load_ext;

    always_comb begin
        rbyte = dm_rdata[{acc_off_q, 3'b000} +: 8];
        rhalf = acc_off_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        case (acc_op_q)
            OP_LB:   load_ext = {{24{rbyte[7]}}, rbyte};
            OP_LBU:  load_ext = {24'd0, rbyte};
            OP_LH:   load_ext = {{16{rhalf[15]}}, rhalf};
            OP_LHU:  load_ext = {16'd0, rhalf};
            default: load_ext = dm_rdata;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        dm_req_d       = dm_req_q;
        dm_we_d        = dm_we_q;
        dm_addr_d      = dm_addr_q;
        dm_wdata_d     = dm_wdata_q;
        dm_be_d        = dm_be_q;
        wb_valid_d     = 1'b0;
        wb_data_d      = wb_data_q;
        wb_rd_d        = wb_rd_q;
        wb_reg_write_d = 1'b0;
        misalign_d     = 1'b0;
        acc_op_d       = acc_op_q;
        acc_off_d      = acc_off_q;
        acc_rd_d       = acc_rd_q;
        acc_rw_d       = acc_rw_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d          = '0;
`endif
        case (state_q)
            IDLE: begin
                if (ex_valid && !flush) begin
                    if (!is_mem) begin
                        wb_valid_d     = 1'b1;
                        wb_data_d      = ex_alu_res;
                        wb_rd_d        = ex_rd;
                        wb_reg_write_d = ex_reg_write;
                    end else if (misaligned) begin
                        wb_valid_d = 1'b1;
                        misalign_d = 1'b1;
                        wb_data_d  = ex_alu_res;
                        wb_rd_d    = ex_rd;
                    end else begin
                        state_d    = ACCESS;
                        dm_req_d   = 1'b1;
                        dm_we_d    = is_store;
                        dm_addr_d  = {ex_alu_res[31:2], 2'b00};
                        dm_be_d    = be_c;
                        dm_wdata_d = wdata_c;
                        acc_op_d   = ex_mem_op;
                        acc_off_d  = off;
                        acc_rd_d   = ex_rd;
                        acc_rw_d   = ex_reg_write;
                    end
                end
            end
            ACCESS: begin
                if (dm_ack) begin
                    state_d        = IDLE;
                    dm_req_d       = 1'b0;
                    wb_valid_d     = 1'b1;
                    wb_rd_d        = acc_rd_q;
                    wb_reg_write_d = acc_rw_q && !dm_we_q;
                    wb_data_d      = dm_we_q ? {dm_addr_q[31:2], acc_off_q} : load_ext;
                end
`ifdef MEM_TIMEOUT_EN
                // Ack on the final counted cycle takes the branch above.
                else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_d    = IDLE;
                    dm_req_d   = 1'b0;
                    wb_valid_d = 1'b1;
                    misalign_d = 1'b1;
                    wb_rd_d    = acc_rd_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            dm_req_q       <= 1'b0;
            dm_we_q        <= 1'b0;
            dm_addr_q      <= '0;
            dm_wdata_q     <= '0;
            dm_be_q        <= '0;
            wb_valid_q     <= 1'b0;
            wb_data_q      <= '0;
            wb_rd_q        <= '0;
            wb_reg_write_q <= 1'b0;
            misalign_q     <= 1'b0;
            acc_op_q       <= '0;
            acc_off_q      <= '0;
            acc_rd_q       <= '0;
            acc_rw_q       <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            dm_req_q       <= dm_req_d;
            dm_we_q        <= dm_we_d;
            dm_addr_q      <= dm_addr_d;
            dm_wdata_q     <= dm_wdata_d;
            dm_be_q        <= dm_be_d;
            wb_valid_q     <= wb_valid_d;
            wb_data_q      <= wb_data_d;
            wb_rd_q        <= wb_rd_d;
            wb_reg_write_q <= wb_reg_write_d;
            misalign_q     <= misalign_d;
            acc_op_q       <= acc_op_d;
            acc_off_q      <= acc_off_d;
            acc_rd_q       <= acc_rd_d;
            acc_rw_q       <= acc_rw_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q          <= cnt_d;
`endif
        end
    end

    assign mem_stall    = (state_q == ACCESS);
    assign dm_req       = dm_req_q;
    assign dm_we        = dm_we_q;
    assign dm_addr      = dm_addr_q;
    assign dm_wdata     = dm_wdata_q;
    assign dm_be        = dm_be_q;
    assign wb_valid     = wb_valid_q;
    assign wb_data      = wb_data_q;
    assign wb_rd        = wb_rd_q;
    assign wb_reg_write = wb_reg_write_q;
    assign misalign     = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: table of instructions with hand-computed results, plus
// sequences for flush, idle ack, async reset and (with MEM_TIMEOUT_EN) the ack watchdog.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_alu_res;
    logic [31:0] ex_wdata;
    logic [3:0]  ex_mem_op;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        flush;
    logic        mem_stall;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic        misalign;

    mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_alu_res(ex_alu_res), .ex_wdata(ex_wdata),
        .ex_mem_op(ex_mem_op), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .flush(flush), .mem_stall(mem_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_reg_write(wb_reg_write), .misalign(misalign)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected retirement: {data_care, misalign, reg_write, rd[4:0], data[31:0]}
    localparam int W = 40;
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] rdata;
        int          ack_dly;
        logic        exp_req;
        logic        exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic        exp_care;
        logic [31:0] exp_data;
        logic        exp_rw;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [4:0] rd, input logic rw,
                                input logic [31:0] rdata, input int dly, input logic req,
                                input logic we, input logic [3:0] be, input logic [31:0] swd,
                                input logic care, input logic [31:0] data, input logic erw,
                                input logic mis);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wdata; v.rd = rd; v.rw = rw;
        v.rdata = rdata; v.ack_dly = dly; v.exp_req = req; v.exp_we = we;
        v.exp_be = be; v.exp_wdata = swd; v.exp_care = care; v.exp_data = data;
        v.exp_rw = erw; v.exp_mis = mis;
        return v;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [4:0] rd, input logic rw, input logic fl);
        ex_valid = 1'b1; ex_mem_op = op; ex_alu_res = addr; ex_wdata = wd;
        ex_rd = rd; ex_reg_write = rw; flush = fl;
    endtask

    task automatic idle_ex;
        ex_valid = 1'b0; ex_mem_op = 4'd0; flush = 1'b0;
        ex_alu_res = $urandom(); ex_wdata = $urandom();
    endtask

    // Scoreboard: compare one retirement against the head of exp_q.
    task automatic check_wb;
        logic [W-1:0] e;
        chk("wb_valid", wb_valid, 1);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_underflow: got retirement, expected none");
        end else begin
            e = exp_q.pop_front();
            if (wb_valid) begin
                if (e[39]) chk("wb_data", wb_data, e[31:0]);
                chk("wb_rd", wb_rd, e[36:32]);
                chk("wb_reg_write", wb_reg_write, e[37]);
                chk("misalign", misalign, e[38]);
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int stall_cnt;
        drive_ex(v.op, v.addr, v.wdata, v.rd, v.rw, 1'b0);
        exp_q.push_back({v.exp_care, v.exp_mis, v.exp_rw, v.rd, v.exp_data});
        tick();
        idle_ex();
        if (v.exp_req) begin
            chk($sformatf("v%0d_req", idx), dm_req, 1);
            chk($sformatf("v%0d_we", idx), dm_we, v.exp_we);
            chk($sformatf("v%0d_addr", idx), dm_addr, v.addr & 32'hFFFF_FFFC);
            chk($sformatf("v%0d_be", idx), dm_be, v.exp_be);
            if (v.exp_we) chk($sformatf("v%0d_wdata", idx), dm_wdata, v.exp_wdata);
            stall_cnt = 0;
            for (int i = 0; i < v.ack_dly; i++) begin
                if (mem_stall) stall_cnt++;
                chk($sformatf("v%0d_hold", idx), {dm_req, wb_valid, dm_be, dm_addr},
                    {1'b1, 1'b0, v.exp_be, v.addr & 32'hFFFF_FFFC});
                tick();
            end
            if (mem_stall) stall_cnt++;
            dm_ack = 1'b1;
            dm_rdata = v.rdata;
            tick();
            dm_ack = 1'b0;
            dm_rdata = $urandom();
            chk($sformatf("v%0d_stall_cycles", idx), stall_cnt, v.ack_dly + 1);
            chk($sformatf("v%0d_req_drop", idx), {dm_req, mem_stall}, 0);
        end else begin
            chk($sformatf("v%0d_no_req", idx), {dm_req, mem_stall}, 0);
        end
        check_wb();
        tick();
        chk($sformatf("v%0d_pulse_end", idx), {wb_valid, misalign}, 0);
    endtask

    initial begin
        rst = 1'b1; dm_ack = 1'b0; dm_rdata = '0;
        idle_ex();

        // op, addr, wdata, rd, rw, rdata, dly, req, we, be, st_wdata, care, wb_data, wb_rw, mis
        vecs.push_back(mk(4'd0, 32'h0000_1234, 0, 5, 1, 0, 0, 0, 0, 0, 0, 1, 32'h0000_1234, 1, 0));
        vecs.push_back(mk(4'd1, 32'h0000_0103, 0, 7, 1, 32'h80FF_FFFF, 1, 1, 0, 4'b1000, 0, 1, 32'hFFFF_FF80, 1, 0));
        vecs.push_back(mk(4'd7, 32'h0000_0102, 32'h0000_ABCD, 9, 1, 0, $urandom_range(0, 3), 1, 1, 4'b1100, 32'hABCD_ABCD, 0, 0, 0, 0));
        vecs.push_back(mk(4'd5, 32'h0000_0101, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(4'd2, 32'h0000_0101, 0, 11, 1, 32'h1234_8056, $urandom_range(0, 3), 1, 0, 4'b0010, 0, 1, 32'h0000_0080, 1, 0));
        vecs.push_back(mk(4'd3, 32'h0000_0102, 0, 12, 1, 32'h8001_7FFF, $urandom_range(0, 3), 1, 0, 4'b1100, 0, 1, 32'hFFFF_8001, 1, 0));
        vecs.push_back(mk(4'd4, 32'h0000_0100, 0, 13, 1, 32'h1111_F00D, $urandom_range(0, 3), 1, 0, 4'b0011, 0, 1, 32'h0000_F00D, 1, 0));
        vecs.push_back(mk(4'd5, 32'h0000_0200, 0, 14, 1, 32'hDEAD_BEEF, $urandom_range(0, 3), 1, 0, 4'b1111, 0, 1, 32'hDEAD_BEEF, 1, 0));
        vecs.push_back(mk(4'd6, 32'h0000_0301, 32'h1234_5678, 15, 1, 0, $urandom_range(0, 3), 1, 1, 4'b0010, 32'h7878_7878, 0, 0, 0, 0));
        vecs.push_back(mk(4'd8, 32'h0000_0304, 32'hCAFE_F00D, 16, 1, 0, $urandom_range(0, 3), 1, 1, 4'b1111, 32'hCAFE_F00D, 0, 0, 0, 0));
        vecs.push_back(mk(4'd3, 32'h0000_0101, 0, 17, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(4'd7, 32'h0000_0203, 32'h0000_1111, 18, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(4'd12, 32'h0000_55AA, 0, 3, 1, 0, 0, 0, 0, 0, 0, 1, 32'h0000_55AA, 1, 0));
        vecs.push_back(mk(4'd1, 32'h0000_0100, 0, 19, 1, 32'h0000_007F, 0, 1, 0, 4'b0001, 0, 1, 32'h0000_007F, 1, 0));
        vecs.push_back(mk(4'd0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF, 0, 0));
        vecs.push_back(mk(4'd3, 32'h0000_0100, 0, 20, 1, 32'h0000_8000, $urandom_range(0, 3), 1, 0, 4'b0011, 0, 1, 32'hFFFF_8000, 1, 0));
        vecs.push_back(mk(4'd6, 32'h0000_0103, 32'h0000_00A5, 21, 1, 0, $urandom_range(0, 3), 1, 1, 4'b1000, 32'hA5A5_A5A5, 0, 0, 0, 0));

        // Reset state
        tick(); tick();
        chk("reset_outputs", {mem_stall, dm_req, dm_we, dm_be, wb_valid, wb_reg_write, misalign}, 0);
        chk("reset_dm_addr", dm_addr, 0);
        chk("reset_wb_data", {wb_rd, wb_data}, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // Misaligned op with flush: nothing retires
        drive_ex(4'd5, 32'h0000_0101, 0, 4, 1, 1'b1);
        tick();
        idle_ex();
        chk("flush_idle_0", {wb_valid, misalign, dm_req}, 0);
        tick();
        chk("flush_idle_1", {wb_valid, misalign, dm_req}, 0);

        // Flush and new offers during ACCESS do not disturb the older access
        drive_ex(4'd5, 32'h0000_0500, 0, 10, 1, 1'b0);
        exp_q.push_back({1'b1, 1'b0, 1'b1, 5'd10, 32'h0BAD_F00D});
        tick();
        drive_ex(4'd0, 32'h0000_0777, 0, 2, 1, 1'b1);
        tick();
        chk("acc_flush_hold", {dm_req, mem_stall, wb_valid}, 3'b110);
        drive_ex(4'd0, 32'h0000_0888, 0, 2, 1, 1'b0);
        tick();
        chk("acc_ignore_ex", {dm_req, mem_stall, wb_valid}, 3'b110);
        idle_ex();
        dm_ack = 1'b1; dm_rdata = 32'h0BAD_F00D;
        tick();
        dm_ack = 1'b0;
        check_wb();
        tick();
        chk("acc_no_extra_retire", {wb_valid, dm_req}, 0);

        // Ack while idle is ignored
        dm_ack = 1'b1;
        tick();
        dm_ack = 1'b0;
        chk("idle_ack_ignored", {wb_valid, dm_req, mem_stall}, 0);

        // Async reset in the middle of an access
        drive_ex(4'd5, 32'h0000_0400, 0, 6, 1, 1'b0);
        tick();
        idle_ex();
        chk("rst_pre_req", {dm_req, mem_stall}, 2'b11);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_clear", {dm_req, mem_stall, wb_valid}, 0);
        tick();
        rst = 1'b0;
        tick();
        run_vec(mk(4'd0, 32'h0000_0042, 0, 8, 1, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0042, 1, 0), 100);

`ifdef MEM_TIMEOUT_EN
        // Watchdog: no ack for 4 access cycles
        drive_ex(4'd5, 32'h0000_0600, 0, 22, 1, 1'b0);
        exp_q.push_back({1'b0, 1'b1, 1'b0, 5'd22, 32'h0});
        tick();
        idle_ex();
        for (int i = 0; i < 4; i++) begin
            chk("to_req_held", {dm_req, mem_stall}, 2'b11);
            tick();
        end
        chk("to_req_drop", {dm_req, mem_stall}, 0);
        check_wb();
        tick();
        chk("to_pulse_end", {wb_valid, misalign}, 0);
`endif

        chk("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
